// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, datapath width and the
// multiply/divide sequencer state type.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b0001;
   localparam logic [3:0] ALU_SLT    = 4'b0010;
   localparam logic [3:0] ALU_OR     = 4'b0011;
   localparam logic [3:0] ALU_AND    = 4'b0100;

   localparam logic [3:0] ALU_MUL    = 4'b1000;
   localparam logic [3:0] ALU_MULH   = 4'b1001;
   localparam logic [3:0] ALU_MULHSU = 4'b1010;
   localparam logic [3:0] ALU_MULHU  = 4'b1011;
   localparam logic [3:0] ALU_DIV    = 4'b1100;
   localparam logic [3:0] ALU_DIVU   = 4'b1101;
   localparam logic [3:0] ALU_REM    = 4'b1110;
   localparam logic [3:0] ALU_REMU   = 4'b1111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_ADJ  = 2'd2,
      MD_DONE = 2'd3
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative engine: a shift-add multiply step or a
// restoring-divide step on the shared double-width accumulator.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic              mode,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] acc_nxt,
   output logic              q_bit
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_shift;
   logic [XLEN-1:0] diff;
   logic [XLEN-1:0] rem_new;

   always_comb begin
      sum       = '0;
      rem_shift = '0;
      diff      = '0;
      rem_new   = '0;
      q_bit     = 1'b0;
      acc_nxt   = '0;
      if (mode) begin
         // Divide: acc = {partial remainder, dividend bits / quotient bits}.
         // The quotient bit lands in the lsb, which is left 0 here.
         rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
         q_bit     = (rem_shift >= {1'b0, operand});
         diff      = rem_shift[XLEN-1:0] - operand;
         rem_new   = q_bit ? diff : rem_shift[XLEN-1:0];
         acc_nxt   = {rem_new, acc[XLEN-2:0], 1'b0};
      end else begin
         sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
         acc_nxt = {sum, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer with start/busy/done handshake.
// Operands are made unsigned on accept; the sign is restored in ADJ.
//
// state   | meaning
// IDLE    | waiting for an accepted start
// CALC    | one multiply/divide iteration per cycle, CYCLES cycles
// ADJ     | sign fix-up and half/quotient/remainder select into result
// DONE    | done pulse, result valid; a new start may be accepted here
module muldiv_seq #(
   parameter int XLEN   = 32,
   parameter int CYCLES = XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_op1,
   input  logic [XLEN-1:0] alu_op2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   import alu_pkg::*;

   localparam int CNT_W = $clog2(CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
   localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t     state, state_nxt;
   logic [2*XLEN-1:0] acc, step_acc, prod_adj;
   logic [XLEN-1:0]   opnd, abs1, abs2, special_val, half, res_adj;
   logic [CNT_W-1:0]  cnt;
   logic              neg, sel_hi, is_div;
   logic              step_q, accept, special;
   logic              s1, s2, div0, ovf, neg_in, sel_hi_in;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .mode    (is_div),
      .acc     (acc),
      .operand (opnd),
      .acc_nxt (step_acc),
      .q_bit   (step_q)
   );

   always_comb begin
      s1 = alu_op1[XLEN-1] & (alu_ctrl inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
      s2 = alu_op2[XLEN-1] & (alu_ctrl inside {ALU_MULH, ALU_DIV, ALU_REM});
      abs1 = s1 ? -alu_op1 : alu_op1;
      abs2 = s2 ? -alu_op2 : alu_op2;
      // Remainder follows the dividend; everything else is sign1 ^ sign2.
      neg_in    = (alu_ctrl == ALU_REM) ? s1 : (s1 ^ s2);
      // Upper half means MULH* product high word or the division remainder.
      sel_hi_in = alu_ctrl[1] | (alu_ctrl[0] & ~alu_ctrl[2]);
      div0 = alu_ctrl[2] & (alu_op2 == '0);
      ovf  = (alu_ctrl inside {ALU_DIV, ALU_REM}) & (alu_op1 == MIN_INT) & (alu_op2 == '1);
      special = div0 | ovf;
      if (div0) special_val = alu_ctrl[1] ? alu_op1 : '1;
      else      special_val = alu_ctrl[1] ? '0 : MIN_INT;
   end

   always_comb begin
      half     = '0;
      res_adj  = '0;
      prod_adj = neg ? -acc : acc;
      if (is_div) begin
         half    = sel_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
         res_adj = neg ? -half : half;
      end else begin
         res_adj = sel_hi ? prod_adj[2*XLEN-1:XLEN] : prod_adj[XLEN-1:0];
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = start & ~flush & alu_ctrl[3] & ((state == MD_IDLE) | (state == MD_DONE));
      case (state)
         MD_IDLE: if (accept) state_nxt = special ? MD_DONE : MD_CALC;
         MD_CALC: if (cnt == CNT_LAST) state_nxt = MD_ADJ;
         MD_ADJ:  state_nxt = MD_DONE;
         MD_DONE: state_nxt = accept ? (special ? MD_DONE : MD_CALC) : MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
      if (flush) state_nxt = MD_IDLE;
   end

   assign busy = (state == MD_CALC) | (state == MD_ADJ);
   assign done = (state == MD_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= MD_IDLE;
         acc    <= '0;
         opnd   <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         sel_hi <= 1'b0;
         is_div <= 1'b0;
         result <= '0;
      end else begin
         state <= state_nxt;
         if (flush) begin
            cnt <= '0;
         end else if (accept) begin
            acc    <= {{XLEN{1'b0}}, abs1};
            opnd   <= abs2;
            neg    <= neg_in;
            sel_hi <= sel_hi_in;
            is_div <= alu_ctrl[2];
            cnt    <= '0;
            if (special) result <= special_val;
         end else if (state == MD_CALC) begin
            acc <= step_acc | {{(2*XLEN-1){1'b0}}, step_q};
            cnt <= cnt + 1'b1;
         end else if (state == MD_ADJ) begin
            result <= res_adj;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, busy profile, flush,
// ignored start and asynchronous reset.
module tb_muldiv_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_res;

   muldiv_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .alu_ctrl (alu_ctrl),
      .alu_op1  (alu_op1),
      .alu_op2  (alu_op2),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op; inj>0 pulses a second start in that cycle with other operands.
   task automatic do_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int inj);
      int lat;
      int bcnt;
      alu_ctrl = ctrl;
      alu_op1  = a;
      alu_op2  = b;
      start    = 1'b1;
      tick();
      start = 1'b0;
      lat   = 1;
      bcnt  = 0;
      while (!done && lat < 60) begin
         if (busy) bcnt++;
         if (lat == inj) begin
            start   = 1'b1;
            alu_op1 = 32'd100;
            alu_op2 = 32'd100;
         end
         tick();
         start = 1'b0;
         lat++;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busycyc"}, 32'(bcnt), 32'(exp_lat - 1));
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({tag, "_result"}, result, exp);
      last_res = exp;
      tick();
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      flush    = 1'b0;
      alu_ctrl = 4'b0000;
      alu_op1  = '0;
      alu_op2  = '0;
      last_res = '0;
      #2;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Non-M code with start must be ignored.
      alu_ctrl = ALU_ADD;
      alu_op1  = 32'd5;
      alu_op2  = 32'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("nonm_busy", {31'd0, busy}, 32'd0);
      chk("nonm_done", {31'd0, done}, 32'd0);

      do_op("mulhu_ff", ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
      do_op("mul_ff",   ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34, 0);
      do_op("div_m7_2", ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
      do_op("rem_m7_2", ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
      do_op("mulhsu",   ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 0);
      do_op("mulh_m2",  ALU_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 34, 0);
      do_op("div_7_m2", ALU_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
      do_op("rem_7_m2", ALU_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34, 0);
      do_op("divu0",    ALU_DIVU,   32'd123,       32'd0,         32'hFFFF_FFFF, 1,  0);
      do_op("remu0",    ALU_REMU,   32'd123,       32'd0,         32'd123,       1,  0);
      do_op("div_ovf",  ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
      do_op("rem_ovf",  ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  0);
      do_op("divu_100", ALU_DIVU,   32'd100,       32'd7,         32'd14,        34, 0);

      // Flush in cycle 10 of a DIVU, together with a start that must be dropped.
      alu_ctrl = ALU_DIVU;
      alu_op1  = 32'd1000;
      alu_op2  = 32'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      chk("fl_busy_c10", {31'd0, busy}, 32'd1);
      flush    = 1'b1;
      start    = 1'b1;
      alu_ctrl = ALU_MUL;
      alu_op1  = 32'd9;
      alu_op2  = 32'd9;
      tick();
      flush = 1'b0;
      start = 1'b0;
      chk("fl_busy_c11", {31'd0, busy}, 32'd0);
      chk("fl_done_c11", {31'd0, done}, 32'd0);
      tick();
      chk("fl_done_c12", {31'd0, done}, 32'd0);
      chk("fl_result_held", result, last_res);
      do_op("mul_6x7", ALU_MUL, 32'd6, 32'd7, 32'd42, 34, 0);

      // Start pulsed in cycle 5 of a running MUL is ignored.
      do_op("mul_ign", ALU_MUL, 32'd3, 32'd5, 32'd15, 34, 5);

      // Asynchronous reset in the middle of CALC.
      alu_ctrl = ALU_MULHU;
      alu_op1  = 32'hFFFF_FFFF;
      alu_op2  = 32'hFFFF_FFFF;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_result", result, 32'd0);
      tick();
      rst_n = 1'b1;
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      tick();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      do_op("remu_100", ALU_REMU, 32'd100, 32'd7, 32'd2, 34, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
